mem_arbiter: RTL and testbench

- Single owner of the byte-wide unified RAM port. Shares it between instruction fetch (IF) and memory access (MA).
- Sequences each multi-byte access as consecutive byte cycles.
- Produces `if_stall_req` / `ma_stall_req` for the pipeline stall controller.
- Sits between the IF/MA stages and the external RAM, alongside the stall controller.

---
 rtl/mem_arbiter_pkg.sv | 38 +++
 rtl/mem_arbiter_byte_seq.sv | 87 ++++++++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_pkg
//  Description : Shared state encodings, ma_len codes and RAM interface
//                widths for the unified byte-wide RAM port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Arbiter states: idle, IF word read, MA read, MA write.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IF_RD = 2'd1,
    ST_MA_RD = 2'd2,
    ST_MA_WR = 2'd3
  } arb_state_t;

  // ma_len codes; 2'b11 falls through to a word access.
  localparam logic [1:0] c_len_byte = 2'b00;
  localparam logic [1:0] c_len_half = 2'b01;
  localparam logic [1:0] c_len_word = 2'b10;

  // RAM data width, transfer width and byte-counter width (counts 0..4).
  localparam int unsigned c_mem_data_w = 8;
  localparam int unsigned c_xfer_w     = 32;
  localparam int unsigned c_cnt_w      = 3;

  // Number of byte cycles for an MA access of the given length code.
  function automatic logic [c_cnt_w-1:0] len_to_n(input logic [1:0] len);
    case (len)
      c_len_byte: return c_cnt_w'(1);
      c_len_half: return c_cnt_w'(2);
      default:    return c_cnt_w'(4);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_byte_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_byte_seq
//  Description : Issue/capture byte counter pair for one granted access.
//                Reads pipeline one byte per cycle with a one-cycle RAM
//                latency; a byte whose issue or capture cycle saw rdy low
//                is re-issued. Writes simply step one byte per rdy cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_byte_seq
  import mem_arbiter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    start,
  input  logic                    active,
  input  logic                    is_wr,
  input  logic [c_cnt_w-1:0]      n_bytes,
  input  logic [c_mem_data_w-1:0] din,
  output logic [c_cnt_w-1:0]      idx,
  output logic                    done,
  output logic [c_xfer_w-1:0]     rbuf_next
);

  logic [c_cnt_w-1:0]  iss_q, iss_d;
  logic [c_cnt_w-1:0]  cap_q, cap_d;
  logic                pend_q, pend_d;   // a byte issued last cycle with rdy high
  logic [c_xfer_w-1:0] buf_q, buf_d;

  // Next-state for counters and the read assembly buffer.
  always_comb begin
    iss_d  = iss_q;
    cap_d  = cap_q;
    pend_d = pend_q;
    buf_d  = buf_q;
    done   = 1'b0;
    if (start) begin
      // Clearing the buffer leaves unused bytes of short loads at zero.
      iss_d  = '0;
      cap_d  = '0;
      pend_d = 1'b0;
      buf_d  = '0;
    end else if (active && is_wr) begin
      if (rdy) begin
        iss_d = iss_q + c_cnt_w'(1);
        done  = (iss_q == n_bytes - c_cnt_w'(1));
      end
    end else if (active) begin
      if (rdy) begin
        if (pend_q) begin
          buf_d[{cap_q[1:0], 3'b000} +: 8] = din;
          cap_d = cap_q + c_cnt_w'(1);
          done  = (cap_q == n_bytes - c_cnt_w'(1));
        end
        pend_d = (iss_q < n_bytes);
        if (iss_q < n_bytes) begin
          iss_d = iss_q + c_cnt_w'(1);
        end
      end else begin
        // Any in-flight byte is lost: rewind issue to the first uncaptured byte.
        pend_d = 1'b0;
        iss_d  = cap_q;
      end
    end
  end

  // Counter and buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_q  <= '0;
      cap_q  <= '0;
      pend_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      iss_q  <= iss_d;
      cap_q  <= cap_d;
      pend_q <= pend_d;
      buf_q  <= buf_d;
    end
  end

  assign idx       = iss_q;
  assign rbuf_next = buf_d;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Owns the byte-wide unified RAM port and shares it between
//                instruction fetch (4-byte reads) and memory access
//                (1/2/4-byte loads and stores). MA wins in IDLE; a grant is
//                held until the access completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    if_req,
  input  logic [ADDR_W-1:0]       if_addr,
  output logic [c_xfer_w-1:0]     if_data,
  output logic                    if_done,
  input  logic                    ma_req,
  input  logic                    ma_we,
  input  logic [1:0]              ma_len,
  input  logic [ADDR_W-1:0]       ma_addr,
  input  logic [c_xfer_w-1:0]     ma_wdata,
  output logic [c_xfer_w-1:0]     ma_rdata,
  output logic                    ma_done,
  input  logic [c_mem_data_w-1:0] mem_din,
  output logic [c_mem_data_w-1:0] mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  output logic                    if_stall_req,
  output logic                    ma_stall_req
);

  if (RD_LAT != 1) begin : g_rd_lat_check
    $error("mem_arbiter: only RD_LAT = 1 is supported");
  end

  arb_state_t          state_q, state_d;
  logic                if_done_q, if_done_d;
  logic                ma_done_q, ma_done_d;
  logic [c_xfer_w-1:0] if_data_q, if_data_d;
  logic [c_xfer_w-1:0] ma_rdata_q, ma_rdata_d;

  logic                seq_start, seq_active, seq_wr, seq_done;
  logic [c_cnt_w-1:0]  seq_n, seq_idx;
  logic [c_xfer_w-1:0] seq_rbuf;
  logic [ADDR_W-1:0]   base;

  mem_arbiter_byte_seq u_byte_seq (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .start     (seq_start),
    .active    (seq_active),
    .is_wr     (seq_wr),
    .n_bytes   (seq_n),
    .din       (mem_din),
    .idx       (seq_idx),
    .done      (seq_done),
    .rbuf_next (seq_rbuf)
  );

  // Arbitration, access sequencing and completion handling.
  always_comb begin
    state_d    = state_q;
    // Done pulses last one cycle, but are held while the pipeline is frozen.
    if_done_d  = if_done_q & ~rdy;
    ma_done_d  = ma_done_q & ~rdy;
    if_data_d  = if_data_q;
    ma_rdata_d = ma_rdata_q;
    seq_start  = 1'b0;
    seq_active = 1'b0;
    seq_wr     = 1'b0;
    seq_n      = c_cnt_w'(4);
    base       = if_addr;
    case (state_q)
      ST_IDLE: begin
        // A requester still showing done is the one just finished; skip it.
        if (rdy) begin
          if (ma_req && !ma_done_q) begin
            seq_start = 1'b1;
            state_d   = ma_we ? ST_MA_WR : ST_MA_RD;
          end else if (if_req && !if_done_q) begin
            seq_start = 1'b1;
            state_d   = ST_IF_RD;
          end
        end
      end
      ST_IF_RD: begin
        seq_active = 1'b1;
        if (seq_done) begin
          state_d   = ST_IDLE;
          if_done_d = 1'b1;
          if_data_d = seq_rbuf;
        end
      end
      ST_MA_RD: begin
        seq_active = 1'b1;
        seq_n      = len_to_n(ma_len);
        base       = ma_addr;
        if (seq_done) begin
          state_d    = ST_IDLE;
          ma_done_d  = 1'b1;
          ma_rdata_d = seq_rbuf;
        end
      end
      ST_MA_WR: begin
        seq_active = 1'b1;
        seq_wr     = 1'b1;
        seq_n      = len_to_n(ma_len);
        base       = ma_addr;
        if (seq_done) begin
          state_d   = ST_IDLE;
          ma_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, done pulses and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      if_done_q  <= 1'b0;
      ma_done_q  <= 1'b0;
      if_data_q  <= '0;
      ma_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      if_done_q  <= if_done_d;
      ma_done_q  <= ma_done_d;
      if_data_q  <= if_data_d;
      ma_rdata_q <= ma_rdata_d;
    end
  end

  // RAM port is quiet (all zero) whenever no access is in progress.
  assign mem_a    = (state_q == ST_IDLE) ? '0 : base + ADDR_W'(seq_idx);
  assign mem_wr   = (state_q == ST_MA_WR) && rdy;
  assign mem_dout = (state_q == ST_MA_WR) ? ma_wdata[{seq_idx[1:0], 3'b000} +: 8] : '0;

  assign if_data      = if_data_q;
  assign if_done      = if_done_q;
  assign ma_rdata     = ma_rdata_q;
  assign ma_done      = ma_done_q;
  assign if_stall_req = if_req & ~if_done_q;
  assign ma_stall_req = ma_req & ~ma_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Scoreboard bench for mem_arbiter with a 1-cycle-latency
//                byte RAM model and directed IF/MA transactions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_req, ma_req, ma_we;
  logic [31:0] if_addr, ma_addr, ma_wdata;
  logic [1:0]  ma_len;
  logic [31:0] if_data, ma_rdata, mem_a;
  logic        if_done, ma_done, mem_wr, if_stall_req, ma_stall_req;
  logic [7:0]  mem_din, mem_dout;

  mem_arbiter #(.ADDR_W(32), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .ma_req(ma_req), .ma_we(ma_we), .ma_len(ma_len), .ma_addr(ma_addr),
    .ma_wdata(ma_wdata), .ma_rdata(ma_rdata), .ma_done(ma_done),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .if_stall_req(if_stall_req), .ma_stall_req(ma_stall_req)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered read (one cycle latency), write on strobe, preload port.
  logic [7:0]  ram [0:16383];
  logic        ld_en = 1'b0;
  logic [13:0] ld_addr;
  logic [7:0]  ld_data;
  always @(posedge clk) begin
    mem_din <= ram[mem_a[13:0]];
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (mem_wr) ram[mem_a[13:0]] <= mem_dout;
  end

  typedef struct { logic [31:0] data; bit chk; int cyc; } done_t;
  typedef struct { logic [31:0] addr; logic [7:0] data; int cyc; } wr_t;
  done_t if_q[$];
  done_t ma_q[$];
  wr_t   wr_q[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Completion monitors.
  always @(negedge clk) begin : mon_if
    done_t e;
    if (if_done) begin
      if (if_q.size() == 0) check("if_done unexpected", 32'd1, 32'd0);
      else begin
        e = if_q.pop_front();
        check("if_data", if_data, e.data);
        check("if_done cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon_ma
    done_t e;
    if (ma_done) begin
      if (ma_q.size() == 0) check("ma_done unexpected", 32'd1, 32'd0);
      else begin
        e = ma_q.pop_front();
        if (e.chk) check("ma_rdata", ma_rdata, e.data);
        check("ma_done cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon_wr
    wr_t w;
    if (mem_wr) begin
      if (wr_q.size() == 0) check("mem_wr unexpected", {24'd0, mem_dout}, 32'hFFFF_FFFF);
      else begin
        w = wr_q.pop_front();
        check("mem_wr addr", mem_a, w.addr);
        check("mem_wr data", {24'd0, mem_dout}, {24'd0, w.data});
        check("mem_wr cycle", cyc, w.cyc);
      end
    end
  end

  task automatic ld_byte(input logic [13:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic ld_word(input logic [13:0] a, input logic [31:0] w);
    for (int b = 0; b < 4; b++) ld_byte(a + 14'(b), w[8*b +: 8]);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [7:0] d, input int off);
    wr_t w;
    w.addr = a; w.data = d; w.cyc = cyc + off;
    wr_q.push_back(w);
  endtask

  task automatic expect_addr_at(input int off, input logic [31:0] a);
    repeat (off + 1) @(negedge clk);
    check("mem_a", mem_a, a);
  endtask

  task automatic wait_done(input bit is_if);
    bit seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (is_if) begin
        if (if_done) seen = 1'b1;
        else check("if_stall_req busy", {31'd0, if_stall_req}, 32'd1);
      end else begin
        if (ma_done) seen = 1'b1;
        else check("ma_stall_req busy", {31'd0, ma_stall_req}, 32'd1);
      end
    end
    if (!seen) check(is_if ? "if_done timeout" : "ma_done timeout", 32'd0, 32'd1);
    else if (is_if) check("if_stall_req at done", {31'd0, if_stall_req}, 32'd0);
    else check("ma_stall_req at done", {31'd0, ma_stall_req}, 32'd0);
  endtask

  task automatic run_if(input logic [31:0] a, input logic [31:0] exp, input int lat);
    done_t e;
    e.data = exp; e.chk = 1'b1; e.cyc = cyc + lat;
    if_q.push_back(e);
    if_addr = a; if_req = 1'b1;
    wait_done(1'b1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic run_ma(input logic we, input logic [1:0] len, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp, input bit chk,
                        input int lat);
    done_t e;
    e.data = exp; e.chk = chk; e.cyc = cyc + lat;
    ma_q.push_back(e);
    ma_we = we; ma_len = len; ma_addr = a; ma_wdata = wd; ma_req = 1'b1;
    wait_done(1'b0);
    @(posedge clk); #1;
    ma_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b1; rdy = 1'b1;
    if_req = 1'b0; ma_req = 1'b0; ma_we = 1'b0; ma_len = 2'b00;
    if_addr = '0; ma_addr = '0; ma_wdata = '0;
    @(posedge clk); #1;
    ld_word(14'h0100, 32'h0000_0013);
    ld_word(14'h0104, 32'h0010_0093);
    ld_word(14'h0200, 32'hDEAD_BEEF);
    ld_word(14'h0400, 32'h4433_2211);
    ld_word(14'h3100, 32'h0000_0000);
    ld_byte(14'h3FFF, 8'h5A);
    ld_byte(14'h0000, 8'hA5);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst mem_a", mem_a, 32'd0);
    check("rst mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst if_data", if_data, 32'd0);
    check("rst ma_rdata", ma_rdata, 32'd0);
    check("rst dones", {30'd0, if_done, ma_done}, 32'd0);
    check("rst stalls", {30'd0, if_stall_req, ma_stall_req}, 32'd0);
    @(posedge clk); #1;

    // 1: IF word fetch, addresses in consecutive cycles, done 6 cycles after request.
    fork
      run_if(32'h100, 32'h0000_0013, 6);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("t1 mem_a", mem_a, (i == 0) ? 32'd0 : 32'h100 + 32'(i - 1));
        end
      end
    join
    idle(1);

    // 2: simultaneous requests, MA first, IF granted in the ma_done cycle.
    fork
      run_ma(1'b0, 2'b10, 32'h200, 32'd0, 32'hDEAD_BEEF, 1'b1, 6);
      run_if(32'h104, 32'h0010_0093, 12);
      expect_addr_at(1, 32'h200);
      expect_addr_at(7, 32'h104);
    join
    idle(1);

    // 3: store half.
    exp_wr(32'h3000, 8'hDD, 1);
    exp_wr(32'h3001, 8'hCC, 2);
    run_ma(1'b1, 2'b01, 32'h3000, 32'hAABB_CCDD, 32'd0, 1'b0, 3);
    idle(2);

    // 4: store byte 0x80, load it back zero-extended; then half and len=11.
    exp_wr(32'h3001, 8'h80, 1);
    run_ma(1'b1, 2'b00, 32'h3001, 32'h0000_0080, 32'd0, 1'b0, 2);
    run_ma(1'b0, 2'b00, 32'h3001, 32'd0, 32'h0000_0080, 1'b1, 3);
    run_ma(1'b0, 2'b01, 32'h3000, 32'd0, 32'h0000_80DD, 1'b1, 4);
    run_ma(1'b0, 2'b11, 32'h200, 32'd0, 32'hDEAD_BEEF, 1'b1, 6);

    // Address wrap across 2^32.
    fork
      run_ma(1'b0, 2'b01, 32'hFFFF_FFFF, 32'd0, 32'h0000_A55A, 1'b1, 4);
      expect_addr_at(1, 32'hFFFF_FFFF);
      expect_addr_at(2, 32'h0000_0000);
    join
    idle(1);

    // 5: rdy low for 3 cycles after byte 1 issue; byte 1 re-issued on resume.
    fork
      run_if(32'h400, 32'h4433_2211, 10);
      expect_addr_at(2, 32'h401);
      expect_addr_at(6, 32'h401);
      begin
        repeat (3) @(posedge clk);
        #1 rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy = 1'b1;
      end
    join
    idle(1);

    // 6: reset during a word store after 2 bytes.
    exp_wr(32'h3100, 8'h44, 1);
    exp_wr(32'h3101, 8'h33, 2);
    ma_we = 1'b1; ma_len = 2'b10; ma_addr = 32'h3100; ma_wdata = 32'h1122_3344; ma_req = 1'b1;
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0; ma_req = 1'b0;
    @(negedge clk);
    check("t6 mem_wr after rst", {31'd0, mem_wr}, 32'd0);
    check("t6 mem_a after rst", mem_a, 32'd0);
    check("t6 ma_done after rst", {31'd0, ma_done}, 32'd0);
    check("t6 ma_rdata after rst", ma_rdata, 32'd0);
    check("t6 if_data after rst", if_data, 32'd0);
    idle(3);
    run_ma(1'b0, 2'b10, 32'h3100, 32'd0, 32'h0000_3344, 1'b1, 6);
    for (int b = 0; b < 4; b++) begin
      logic [31:0] wv;
      wv = 32'hCAFE_F00D;
      exp_wr(32'h3100 + 32'(b), wv[8*b +: 8], b + 1);
    end
    run_ma(1'b1, 2'b10, 32'h3100, 32'hCAFE_F00D, 32'd0, 1'b0, 5);
    run_ma(1'b0, 2'b10, 32'h3100, 32'd0, 32'hCAFE_F00D, 1'b1, 6);

    idle(5);
    check("if scoreboard drained", if_q.size(), 32'd0);
    check("ma scoreboard drained", ma_q.size(), 32'd0);
    check("write scoreboard drained", wr_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
